cabac_byte_writer: RTL and testbench

Output-side byte emitter for the CABAC arithmetic encoder: the transmit counterpart of the decoder's byte-request/bits-needed path. It accepts 9-bit lead bytes (carry + byte) from the encoder's low-register renormalization stage. It holds the most recent byte and a run of pending 0xFF bytes until carry resolution is known, then emits the resolved bytes one per cycle on a valid/ready stream toward the bitstream packer. A flush request resolves the final carry at slice end.

---
 rtl/cabac_byte_writer.sv | 136 +++++++++++++
 tb/tb_cabac_byte_writer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_byte_writer.sv
// CABAC output byte emitter: holds the latest lead byte plus a run of pending 0xFF bytes
// until the carry is known, then streams the resolved bytes. Optional macro: CABAC_BW_STATS_EN.
module cabac_byte_writer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [8:0]  in_lead,
  output logic        in_ready,
  input  logic        flush_req,
  input  logic        flush_carry,
  output logic        flush_done,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  input  logic        out_ready,
  output logic [1:0]  err,
  output logic [31:0] bytes_out
);

  typedef enum logic [1:0] {StEmpty, StHold, StDrain, StFdrain} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q;
  logic [7:0]       buf_byte_q;
  logic             buf_valid_q;
  logic [CNT_W-1:0] ff_cnt_q;
  logic [7:0]       run_byte_q;
  logic [CNT_W-1:0] run_left_q;
  logic             out_valid_q;
  logic [7:0]       out_byte_q;
  logic             flush_done_q;
  logic [1:0]       err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StEmpty;
      buf_byte_q   <= 8'h00;
      buf_valid_q  <= 1'b0;
      ff_cnt_q     <= '0;
      run_byte_q   <= 8'h00;
      run_left_q   <= '0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
      flush_done_q <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        StEmpty, StHold: begin
          // A lead byte always wins over a coincident flush request.
          if (in_valid) begin
            if (in_lead == 9'h0FF) begin
              if (state_q == StEmpty) begin
                buf_byte_q  <= 8'hFF;
                buf_valid_q <= 1'b1;
                state_q     <= StHold;
              end else if (ff_cnt_q == CntMax) begin
                err_q[1] <= 1'b1;
              end else begin
                ff_cnt_q <= ff_cnt_q + CNT_W'(1);
              end
            end else if (state_q == StHold) begin
              out_byte_q  <= buf_byte_q + 8'(in_lead[8]);
              out_valid_q <= 1'b1;
              run_byte_q  <= in_lead[8] ? 8'h00 : 8'hFF;
              run_left_q  <= ff_cnt_q;
              buf_byte_q  <= in_lead[7:0];
              ff_cnt_q    <= '0;
              state_q     <= StDrain;
            end else begin
              buf_byte_q  <= in_lead[7:0];
              buf_valid_q <= 1'b1;
              state_q     <= StHold;
              if (in_lead[8] && !buf_valid_q) err_q[0] <= 1'b1;
            end
          end else if (flush_req) begin
            if (state_q == StHold) begin
              out_byte_q  <= buf_byte_q + 8'(flush_carry);
              out_valid_q <= 1'b1;
              run_byte_q  <= flush_carry ? 8'h00 : 8'hFF;
              run_left_q  <= ff_cnt_q;
              state_q     <= StFdrain;
            end else begin
              flush_done_q <= 1'b1;
              if (flush_carry && !buf_valid_q) err_q[0] <= 1'b1;
            end
          end
        end
        StDrain, StFdrain: begin
          if (out_ready) begin
            if (run_left_q == '0) begin
              out_valid_q <= 1'b0;
              if (state_q == StFdrain) begin
                buf_valid_q  <= 1'b0;
                ff_cnt_q     <= '0;
                flush_done_q <= 1'b1;
                state_q      <= StEmpty;
              end else begin
                state_q <= StHold;
              end
            end else begin
              out_byte_q <= run_byte_q;
              run_left_q <= run_left_q - CNT_W'(1);
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

`ifdef CABAC_BW_STATS_EN
  logic [31:0] bytes_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_out_q <= 32'd0;
    end else if (out_valid_q && out_ready) begin
      bytes_out_q <= bytes_out_q + 32'd1;
    end
  end

  assign bytes_out = bytes_out_q;
`else
  assign bytes_out = 32'd0;
`endif

  assign in_ready   = (state_q == StEmpty) || (state_q == StHold);
  assign out_valid  = out_valid_q;
  assign out_byte   = out_byte_q;
  assign flush_done = flush_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cabac_byte_writer.sv
// Directed bench for cabac_byte_writer: a CNT_W=8 instance plus a CNT_W=2 instance
// sharing stimulus, the latter used for run-counter saturation.
module tb_cabac_byte_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [8:0]  in_lead = 9'h000;
  logic        flush_req = 1'b0;
  logic        flush_carry = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, flush_done, out_valid;
  logic [7:0]  out_byte;
  logic [1:0]  err;
  logic [31:0] bytes_out;
  logic        in_ready2, flush_done2, out_valid2;
  logic [7:0]  out_byte2;
  logic [1:0]  err2;
  logic [31:0] bytes_out2;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  cabac_byte_writer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_lead(in_lead), .in_ready(in_ready),
    .flush_req(flush_req), .flush_carry(flush_carry), .flush_done(flush_done),
    .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready), .err(err),
    .bytes_out(bytes_out)
  );

  cabac_byte_writer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_lead(in_lead), .in_ready(in_ready2),
    .flush_req(flush_req), .flush_carry(flush_carry), .flush_done(flush_done2),
    .out_valid(out_valid2), .out_byte(out_byte2), .out_ready(out_ready), .err(err2),
    .bytes_out(bytes_out2)
  );

  // Handshakes are stable at the falling edge, just before the edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) q1.push_back(out_byte);
      if (out_valid2 && out_ready) q2.push_back(out_byte2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush_req = 1'b0; flush_carry = 1'b0; out_ready = 1'b1;
    in_lead = 9'h000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  task automatic send_lead(input logic [8:0] l);
    int n = 0;
    in_lead = l; in_valid = 1'b1;
    while (!in_ready && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) begin
      vectors++; miscompares++;
      $display("FAIL send_lead_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic send_flush(input logic c);
    int n = 0;
    flush_carry = c; flush_req = 1'b1;
    while (!in_ready && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) begin
      vectors++; miscompares++;
      $display("FAIL send_flush_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1 flush_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(in_ready && !out_valid) && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle_timeout: got busy expected idle");
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_byte !== 8'h00) begin miscompares++; $display("FAIL rst_out_byte: got %h expected 00", out_byte); end
    vectors++; if (flush_done !== 1'b0) begin miscompares++; $display("FAIL rst_flush_done: got %b expected 0", flush_done); end
    vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL rst_err: got %b expected 00", err); end
    vectors++; if (bytes_out !== 32'd0) begin miscompares++; $display("FAIL rst_bytes_out: got %0d expected 0", bytes_out); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    do_reset();
    send_lead(9'h012);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_first_quiet: got %b expected 0", out_valid); end
    send_lead(9'h034);
    vectors++; if (out_valid !== 1'b1 || out_byte !== 8'h12) begin
      miscompares++; $display("FAIL basic_emit: got v=%b b=%h expected v=1 b=12", out_valid, out_byte);
    end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready: got %b expected 0", in_ready); end
    wait_idle();
    send_flush(1'b0);
    wait_idle();
    exp_q = '{8'h12, 8'h34};
    vectors++;
    if (q1.size() != exp_q.size()) begin
      miscompares++; $display("FAIL basic_count: got %0d expected %0d", q1.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++; if (q1[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_byte%0d: got %h expected %h", i, q1[i], exp_q[i]); end
    end
  endtask

  task automatic test_carry_run();
    logic [7:0] exp_q[$];
    int cyc = 0;
    do_reset();
    send_lead(9'h012); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h105);
    while (out_valid && cyc < 20) begin cyc++; @(posedge clk); #1; end
    vectors++; if (cyc != 3) begin miscompares++; $display("FAIL run_drain_cycles: got %0d expected 3", cyc); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL run_in_ready_back: got %b expected 1", in_ready); end
    send_flush(1'b0);
    wait_idle();
    exp_q = '{8'h13, 8'h00, 8'h00, 8'h05};
    vectors++;
    if (q1.size() != exp_q.size()) begin
      miscompares++; $display("FAIL run_count: got %0d expected %0d", q1.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++; if (q1[i] !== exp_q[i]) begin miscompares++; $display("FAIL run_byte%0d: got %h expected %h", i, q1[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp_q[$];
    logic prev_hs = 1'b0;
    int n = 0;
    do_reset();
    send_lead(9'h0AB); send_lead(9'h0FF);
    send_flush(1'b0);
    while (!flush_done && n < 20) begin
      prev_hs = out_valid && out_ready; @(posedge clk); #1; n++;
    end
    vectors++; if (flush_done !== 1'b1) begin miscompares++; $display("FAIL flush_done_seen: got %b expected 1", flush_done); end
    vectors++; if (prev_hs !== 1'b1) begin miscompares++; $display("FAIL flush_done_timing: got prev_hs=%b expected 1", prev_hs); end
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush_empty: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    vectors++; if (flush_done !== 1'b0) begin miscompares++; $display("FAIL flush_pulse_len: got %b expected 0", flush_done); end
    exp_q = '{8'hAB, 8'hFF};
    vectors++;
    if (q1.size() != exp_q.size()) begin
      miscompares++; $display("FAIL flush_count: got %0d expected %0d", q1.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++; if (q1[i] !== exp_q[i]) begin miscompares++; $display("FAIL flush_byte%0d: got %h expected %h", i, q1[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] exp_q[$];
    do_reset();
    send_lead(9'h012); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h105);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (out_valid !== 1'b1 || out_byte !== 8'h00 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v=%b b=%h rdy=%b expected v=1 b=00 rdy=0", k, out_valid, out_byte, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle();
    exp_q = '{8'h13, 8'h00, 8'h00};
    vectors++;
    if (q1.size() != exp_q.size()) begin
      miscompares++; $display("FAIL bp_count: got %0d expected %0d", q1.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++; if (q1[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_byte%0d: got %h expected %h", i, q1[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty_errors();
    logic [7:0] exp_q[$];
    do_reset();
    send_flush(1'b1);
    vectors++; if (flush_done !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL empty_flush: got done=%b v=%b expected done=1 v=0", flush_done, out_valid);
    end
    vectors++; if (err !== 2'b01) begin miscompares++; $display("FAIL empty_flush_err: got %b expected 01", err); end
    do_reset();
    send_lead(9'h1AA);
    vectors++; if (err !== 2'b01 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL empty_carry_lead: got err=%b rdy=%b expected err=01 rdy=1", err, in_ready);
    end
    send_flush(1'b0);
    wait_idle();
    exp_q = '{8'hAA};
    vectors++;
    if (q1.size() != exp_q.size() || q1[0] !== exp_q[0]) begin
      miscompares++; $display("FAIL empty_carry_bytes: got n=%0d expected n=1 byte aa", q1.size());
    end
  endtask

  task automatic test_saturate_reset();
    logic [7:0] exp_q[$];
    do_reset();
    send_lead(9'h011);
    repeat (4) send_lead(9'h0FF);
    vectors++; if (err2 !== 2'b10) begin miscompares++; $display("FAIL sat_err2: got %b expected 10", err2); end
    vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL sat_err_wide: got %b expected 00", err); end
    send_lead(9'h022);
    wait_idle();
    exp_q = '{8'h11, 8'hFF, 8'hFF, 8'hFF};
    vectors++;
    if (q2.size() != exp_q.size()) begin
      miscompares++; $display("FAIL sat_count: got %0d expected %0d", q2.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++; if (q2[i] !== exp_q[i]) begin miscompares++; $display("FAIL sat_byte%0d: got %h expected %h", i, q2[i], exp_q[i]); end
    end
    send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h033);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    vectors++; if (out_valid !== 1'b0 || out_valid2 !== 1'b0) begin
      miscompares++; $display("FAIL mid_rst_valid: got %b/%b expected 0/0", out_valid, out_valid2);
    end
    vectors++; if (err2 !== 2'b00 || in_ready2 !== 1'b1) begin
      miscompares++; $display("FAIL mid_rst_state: got err2=%b rdy2=%b expected 00/1", err2, in_ready2);
    end
  endtask

  task automatic test_stats();
    logic [7:0] exp_q[$];
    logic [31:0] exp_cnt;
`ifdef CABAC_BW_STATS_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    send_lead(9'h012); send_lead(9'h0FF); send_lead(9'h0FF); send_lead(9'h105);
    wait_idle();
    send_flush(1'b1);
    wait_idle();
    exp_q = '{8'h13, 8'h00, 8'h00, 8'h06};
    vectors++;
    if (q1.size() != exp_q.size()) begin
      miscompares++; $display("FAIL stats_count: got %0d expected %0d", q1.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      vectors++; if (q1[i] !== exp_q[i]) begin miscompares++; $display("FAIL stats_byte%0d: got %h expected %h", i, q1[i], exp_q[i]); end
    end
    vectors++; if (bytes_out !== exp_cnt) begin
      miscompares++; $display("FAIL stats_bytes_out: got %0d expected %0d", bytes_out, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_run();
    test_flush();
    test_back_pressure();
    test_empty_errors();
    test_saturate_reset();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
